// File: rtl/pwm_phase_sequencer.sv
// PWM phase sequencer: double-buffered pattern table stepped one slot per clock
// through each PWM half-cycle, with a programmable dead-time gap at every edge.
module pwm_phase_sequencer #(
    parameter  int WIDTH     = 8,
    parameter  int NO_SLOTS  = 8,
    parameter  int NO_TWEAK  = 8,
    parameter  int DT_BITS   = 4,
    parameter  int HOLD_LAST = 1,
    localparam int NO_FIELDS = 3 + NO_TWEAK,
    localparam int SLOT_W    = $clog2(NO_SLOTS),
    localparam int FIELD_W   = $clog2(3 + NO_TWEAK)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pwm,
    input  logic [DT_BITS-1:0]          dead_cycles,
    input  logic                        wr_en,
    input  logic                        wr_phase,
    input  logic [SLOT_W-1:0]           wr_slot,
    input  logic [FIELD_W-1:0]          wr_field,
    input  logic [WIDTH-1:0]            wr_data,
    input  logic                        commit,
    output logic                        commit_pending,
    output logic [WIDTH-1:0]            p_drive,
    output logic [WIDTH-1:0]            n_drive,
    output logic [WIDTH-1:0]            tweak_sense,
    output logic [WIDTH-1:0]            tweak_delay,
    output logic [NO_TWEAK*WIDTH-1:0]   tweak_drive,
    output logic [SLOT_W-1:0]           slot,
    output logic                        dead
);

    typedef enum logic {ST_DEAD, ST_ACTIVE} state_t;

    // Tables indexed [phase][slot][field]; phase 0 = P fields, 1 = N fields.
    logic [1:0][NO_SLOTS-1:0][NO_FIELDS-1:0][WIDTH-1:0] shadow_tbl;
    logic [1:0][NO_SLOTS-1:0][NO_FIELDS-1:0][WIDTH-1:0] active_tbl;

    logic                          pwm_s1;
    logic                          pwm_s;
    logic                          pwm_prev;
    logic                          pwm_edge;
    state_t                        state;
    logic [DT_BITS-1:0]            cnt;
    logic [DT_BITS-1:0]            cnt_load;
    logic [SLOT_W-1:0]             slot_next;
    logic [NO_FIELDS-1:0][WIDTH-1:0] row;
    logic                          phase_n;
    logic [WIDTH-1:0]              p_next;
    logic [WIDTH-1:0]              n_next;
    logic [NO_TWEAK*WIDTH-1:0]     tweak_next;

    assign pwm_edge = pwm_s ^ pwm_prev;
    assign cnt_load = (dead_cycles == '0) ? DT_BITS'(1) : dead_cycles;
    // pwm_prev holds the phase currently being driven: 1 = P half-cycle.
    assign phase_n  = ~pwm_prev;
    assign row      = active_tbl[phase_n][slot_next];

    // Two-flop synchroniser for the asynchronous pwm pin plus edge-reference flop
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pwm_s1   <= 1'b0;
            pwm_s    <= 1'b0;
            pwm_prev <= 1'b0;
        end else begin
            pwm_s1   <= pwm;
            pwm_s    <= pwm_s1;
            pwm_prev <= pwm_s;
        end
    end

    // Shadow writes and edge-aligned shadow->active copy; the copy sees pre-write shadow
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shadow_tbl     <= '0;
            active_tbl     <= '0;
            commit_pending <= 1'b0;
        end else begin
            if (pwm_edge && (commit_pending || commit)) begin
                active_tbl     <= shadow_tbl;
                commit_pending <= 1'b0;
            end else if (commit) begin
                commit_pending <= 1'b1;
            end
            if (wr_en && (int'(wr_slot) < NO_SLOTS) && (int'(wr_field) < NO_FIELDS)) begin
                shadow_tbl[wr_phase][wr_slot][wr_field] <= wr_data;
            end
        end
    end

    // Slot to show next clock: 0 on leaving DEAD, else advance with hold or wrap at the end
    always_comb begin
        slot_next = '0;
        if (state == ST_ACTIVE) begin
            if (slot == SLOT_W'(NO_SLOTS - 1)) begin
                slot_next = (HOLD_LAST != 0) ? slot : '0;
            end else begin
                slot_next = slot + 1'b1;
            end
        end
    end

    // Gate and tweak values for the next active slot; only one gate is ever enabled
    always_comb begin
        p_next     = '1;
        n_next     = '0;
        tweak_next = '0;
        if (pwm_prev) begin
            p_next = row[0];
        end else begin
            n_next = row[0];
        end
        for (int k = 0; k < NO_TWEAK; k++) begin
            tweak_next[k*WIDTH +: WIDTH] = row[3+k];
        end
    end

    // Dead-time / slot-stepping FSM with registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_DEAD;
            cnt         <= DT_BITS'(1);
            slot        <= '0;
            dead        <= 1'b1;
            p_drive     <= '1;
            n_drive     <= '0;
            tweak_sense <= '0;
            tweak_delay <= '0;
            tweak_drive <= '0;
        end else if (pwm_edge) begin
            // Any edge, even mid-dead-time, restarts the safe gap
            state       <= ST_DEAD;
            cnt         <= cnt_load;
            slot        <= '0;
            dead        <= 1'b1;
            p_drive     <= '1;
            n_drive     <= '0;
            tweak_sense <= '0;
            tweak_delay <= '0;
            tweak_drive <= '0;
        end else begin
            case (state)
                ST_DEAD: begin
                    if (cnt <= DT_BITS'(1)) begin
                        state       <= ST_ACTIVE;
                        slot        <= slot_next;
                        dead        <= 1'b0;
                        p_drive     <= p_next;
                        n_drive     <= n_next;
                        tweak_sense <= row[1];
                        tweak_delay <= row[2];
                        tweak_drive <= tweak_next;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    slot        <= slot_next;
                    p_drive     <= p_next;
                    n_drive     <= n_next;
                    tweak_sense <= row[1];
                    tweak_delay <= row[2];
                    tweak_drive <= tweak_next;
                end
                default: begin
                    state <= ST_DEAD;
                    cnt   <= DT_BITS'(1);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwm_phase_sequencer.sv
// Bench for pwm_phase_sequencer: two instances (hold-last 8 slots, wrapping 4 slots)
// checked every cycle against a time-since-edge model, plus literal scenario checks.
module tb_pwm_phase_sequencer;

    logic        clk;
    logic        reset;
    logic        pwm;
    logic [3:0]  dead_cycles;
    logic        wr_en;
    logic        wr_phase;
    logic [2:0]  wr_slot;
    logic [3:0]  wr_field;
    logic [7:0]  wr_data;
    logic        commit;

    logic        pend_a, pend_b;
    logic [7:0]  p_a, n_a, se_a, de_a, p_b, n_b, se_b, de_b;
    logic [63:0] tw_a, tw_b;
    logic [2:0]  slot_a;
    logic [1:0]  slot_b;
    logic        dead_a, dead_b;

    int vectors = 0;
    int fails   = 0;

    pwm_phase_sequencer #(.WIDTH(8), .NO_SLOTS(8), .NO_TWEAK(8), .DT_BITS(4), .HOLD_LAST(1)) dut_a (
        .clk(clk), .reset(reset), .pwm(pwm), .dead_cycles(dead_cycles),
        .wr_en(wr_en), .wr_phase(wr_phase), .wr_slot(wr_slot), .wr_field(wr_field),
        .wr_data(wr_data), .commit(commit), .commit_pending(pend_a),
        .p_drive(p_a), .n_drive(n_a), .tweak_sense(se_a), .tweak_delay(de_a),
        .tweak_drive(tw_a), .slot(slot_a), .dead(dead_a)
    );

    pwm_phase_sequencer #(.WIDTH(8), .NO_SLOTS(4), .NO_TWEAK(8), .DT_BITS(4), .HOLD_LAST(0)) dut_b (
        .clk(clk), .reset(reset), .pwm(pwm), .dead_cycles(dead_cycles),
        .wr_en(wr_en), .wr_phase(wr_phase), .wr_slot(wr_slot[1:0]), .wr_field(wr_field),
        .wr_data(wr_data), .commit(commit), .commit_pending(pend_b),
        .p_drive(p_b), .n_drive(n_b), .tweak_sense(se_b), .tweak_delay(de_b),
        .tweak_drive(tw_b), .slot(slot_b), .dead(dead_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pin delay line, cycles since last detected edge, table copies
    logic [7:0] m_sha [2][8][11];
    logic [7:0] m_acta[2][8][11];
    logic [7:0] m_shb [2][4][11];
    logic [7:0] m_actb[2][4][11];
    int  m_k, m_len;
    bit  m_ph, m_h0, m_h1, m_h2, m_pend;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int ph = 0; ph < 2; ph++)
                for (int s = 0; s < 8; s++)
                    for (int f = 0; f < 11; f++) begin
                        m_sha[ph][s][f]  = '0;
                        m_acta[ph][s][f] = '0;
                        m_shb[ph][s%4][f]  = '0;
                        m_actb[ph][s%4][f] = '0;
                    end
            m_k = 0; m_len = 1; m_ph = 0; m_pend = 0;
            m_h0 = 0; m_h1 = 0; m_h2 = 0;
        end else begin
            m_h2 = m_h1; m_h1 = m_h0; m_h0 = pwm;
            if (m_h2 != m_ph) begin
                m_ph  = m_h2;
                m_k   = 0;
                m_len = (dead_cycles == 0) ? 1 : int'(dead_cycles);
                if (m_pend || commit) begin
                    m_acta = m_sha;
                    m_actb = m_shb;
                    m_pend = 0;
                end
            end else begin
                if (m_k < 1000000) m_k++;
                if (commit) m_pend = 1;
            end
            if (wr_en && wr_field < 11) begin
                m_sha[wr_phase][wr_slot][wr_field]     = wr_data;
                m_shb[wr_phase][wr_slot % 4][wr_field] = wr_data;
            end
        end
    end

    logic [7:0]  e_p_a, e_n_a, e_se_a, e_de_a, e_p_b, e_n_b, e_se_b, e_de_b;
    logic [63:0] e_tw_a, e_tw_b;
    int          e_sa, e_sb;
    bit          e_dead;

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (reset) begin
            e_dead = (m_k < m_len);
            e_sa = 0; e_sb = 0;
            e_p_a = 8'hFF; e_n_a = 0; e_se_a = 0; e_de_a = 0; e_tw_a = 0;
            e_p_b = 8'hFF; e_n_b = 0; e_se_b = 0; e_de_b = 0; e_tw_b = 0;
            if (!e_dead) begin
                e_sa = (m_k - m_len > 7) ? 7 : m_k - m_len;
                e_sb = (m_k - m_len) % 4;
                if (m_ph) begin
                    e_p_a = m_acta[0][e_sa][0];
                    e_p_b = m_actb[0][e_sb][0];
                end else begin
                    e_n_a = m_acta[1][e_sa][0];
                    e_n_b = m_actb[1][e_sb][0];
                end
                e_se_a = m_acta[!m_ph][e_sa][1];
                e_de_a = m_acta[!m_ph][e_sa][2];
                e_se_b = m_actb[!m_ph][e_sb][1];
                e_de_b = m_actb[!m_ph][e_sb][2];
                for (int c = 0; c < 8; c++) begin
                    e_tw_a[c*8 +: 8] = m_acta[!m_ph][e_sa][3+c];
                    e_tw_b[c*8 +: 8] = m_actb[!m_ph][e_sb][3+c];
                end
            end
            chk("a_dead", dead_a, e_dead);
            chk("a_slot", slot_a, e_sa);
            chk("a_p", p_a, e_p_a);
            chk("a_n", n_a, e_n_a);
            chk("a_sense", se_a, e_se_a);
            chk("a_delay", de_a, e_de_a);
            chk("a_tweak", tw_a, e_tw_a);
            chk("a_pend", pend_a, m_pend);
            chk("b_dead", dead_b, e_dead);
            chk("b_slot", slot_b, e_sb);
            chk("b_p", p_b, e_p_b);
            chk("b_n", n_b, e_n_b);
            chk("b_tweak", tw_b, e_tw_b);
            chk("b_pend", pend_b, m_pend);
            chk("a_overlap", (p_a != 8'hFF) && (n_a != 8'h00), 0);
            chk("b_overlap", (p_b != 8'hFF) && (n_b != 8'h00), 0);
        end
    end

    logic [7:0] t4v [4];

    // Directed scenarios with literal expectations, then randomized traffic
    initial begin
        t4v[0] = 8'h11; t4v[1] = 8'h22; t4v[2] = 8'h33; t4v[3] = 8'h44;
        reset = 0; pwm = 0; dead_cycles = 4'd3; wr_en = 0; wr_phase = 0;
        wr_slot = 0; wr_field = 0; wr_data = 0; commit = 0;
        repeat (3) @(negedge clk);
        @(posedge clk); #2 reset = 1;

        // Reset state, then N phase with zero table, slots 0..7 holding at 7
        @(negedge clk);
        chk("rst_dead", dead_a, 1);
        chk("rst_p", p_a, 8'hFF);
        chk("rst_slot", slot_a, 0);
        chk("rst_pend", pend_a, 0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t1_slot", slot_a, (i > 7) ? 7 : i);
            chk("t1_dead", dead_a, 0);
            chk("t1_p", p_a, 8'hFF);
            chk("t1_n", n_a, 8'h00);
        end

        // P.DRIVE pattern, commit, edge into P phase with 3-clock dead time
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            wr_en = 1; wr_phase = 0; wr_slot = 3'(i); wr_field = 0; wr_data = 8'(8'hF0 + i);
        end
        @(negedge clk); wr_en = 0; commit = 1;
        @(negedge clk); commit = 0;
        chk("t2_pend_set", pend_a, 1);
        pwm = 1;
        repeat (2) @(negedge clk);
        @(negedge clk);
        chk("t2_dead0", dead_a, 1);
        chk("t2_pend_clr", pend_a, 0);
        repeat (2) begin
            @(negedge clk);
            chk("t2_dead", dead_a, 1);
        end
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("t2_p", p_a, 8'hF0 + i);
            chk("t2_n", n_a, 8'h00);
            chk("t2_dead_off", dead_a, 0);
        end

        // Two edges two clocks apart with minimum dead time
        dead_cycles = 4'd0; pwm = 0;
        repeat (2) @(negedge clk);
        pwm = 1;
        @(negedge clk); chk("t3_dead1", dead_a, 1);
        @(negedge clk); chk("t3_act1", dead_a, 0); chk("t3_np", p_a, 8'hFF);
        @(negedge clk); chk("t3_dead2", dead_a, 1);
        @(negedge clk); chk("t3_act2", dead_a, 0); chk("t3_p0", p_a, 8'hF0);

        // N.TWEAK2 pattern on the wrapping 4-slot instance
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            wr_en = 1; wr_phase = 1; wr_slot = 3'(i); wr_field = 4'd5; wr_data = t4v[i];
        end
        @(negedge clk); wr_en = 0; commit = 1;
        @(negedge clk); commit = 0; pwm = 0;
        repeat (2) @(negedge clk);
        @(negedge clk); chk("t4_dead", dead_b, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_tweak2", tw_b[23:16], t4v[i % 4]);
        end

        // Shadow write without commit, then write coinciding with the commit edge
        @(negedge clk); wr_en = 1; wr_phase = 1; wr_slot = 3'd2; wr_field = 0; wr_data = 8'h5A;
        @(negedge clk); wr_en = 0; commit = 1; pwm = 1;
        @(negedge clk); commit = 0;
        @(negedge clk); wr_en = 1; wr_data = 8'h5B;
        @(negedge clk); wr_en = 0;
        chk("t5_pend", pend_a, 0);
        chk("t5_dead", dead_a, 1);
        pwm = 0;
        repeat (3) @(negedge clk);
        chk("t5_dead_n", dead_a, 1);
        repeat (3) @(negedge clk);
        chk("t5_5a", n_a, 8'h5A);
        @(negedge clk); commit = 1;
        @(negedge clk); commit = 0; pwm = 1;
        repeat (4) @(negedge clk);
        pwm = 0;
        repeat (3) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("t5_5b", n_a, 8'h5B);

        // Asynchronous reset during an active slot with a commit pending
        @(negedge clk); commit = 1;
        @(negedge clk); commit = 0;
        for (int w = 0; w < 20 && slot_a != 3'd4; w++) @(negedge clk);
        chk("t6_slot4", slot_a, 4);
        chk("t6_pend", pend_a, 1);
        @(posedge clk); #2 reset = 0;
        #1;
        chk("t6_p", p_a, 8'hFF);
        chk("t6_n", n_a, 8'h00);
        chk("t6_tw", tw_a, 64'h0);
        chk("t6_dead", dead_a, 1);
        chk("t6_slot", slot_a, 0);
        chk("t6_pend_clr", pend_a, 0);
        @(negedge clk);
        @(posedge clk); #2 reset = 1;

        // Randomized writes (including out-of-range fields), commits, edges, dead times
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            wr_en    = ($urandom_range(0, 2) == 0);
            wr_phase = 1'($urandom_range(0, 1));
            wr_slot  = 3'($urandom_range(0, 7));
            wr_field = 4'($urandom_range(0, 15));
            wr_data  = 8'($urandom_range(0, 255));
            commit   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 24) == 0) pwm = ~pwm;
            if ($urandom_range(0, 9) == 0) dead_cycles = 4'($urandom_range(0, 15));
        end
        @(negedge clk);
        wr_en = 0; commit = 0;
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
